// File: rtl/fft_s_p.sv
// Serial-to-parallel ping-pong input buffer for the 16-point radix-4 FFT.
// Optional completed-frame counter port enabled by FFT_S_P_FRAME_CNT_EN.
module fft_s_p #(
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din_valid,
  input  logic [DATA_W-1:0]   din_re,
  input  logic [DATA_W-1:0]   din_im,
  input  logic                frame_clr,
  output logic                s_p_flag_out,
  output logic                dout_valid,
  output logic [1:0]          dout_grp,
  output logic [4*DATA_W-1:0] dout_re,
  output logic [4*DATA_W-1:0] dout_im
`ifdef FFT_S_P_FRAME_CNT_EN
  ,
  output logic [7:0]          frame_cnt
`endif
);

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned GRP_W  = 2;
  localparam int unsigned BUS_W  = LANES * DATA_W;
  localparam int unsigned FCNT_W = 8;

  localparam logic [CNT_W-1:0] FLAG_IDX = CNT_W'(12);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(15);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN0,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_DRAIN3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic               flag_q, flag_d;
  logic               dout_valid_q, dout_valid_d;
  logic [GRP_W-1:0]   dout_grp_q, dout_grp_d;
  logic [BUS_W-1:0]   dout_re_q, dout_re_d;
  logic [BUS_W-1:0]   dout_im_q, dout_im_d;

  logic [DATA_W-1:0]  mem_re_q [2][DEPTH];
  logic [DATA_W-1:0]  mem_im_q [2][DEPTH];

  logic               wr_en_c;
  logic               last_c;
  logic               drain_c;
  logic [GRP_W-1:0]   grp_c;

  // frame_clr wins over a coincident sample, which is simply dropped
  assign wr_en_c = din_valid && !frame_clr;
  assign last_c  = wr_en_c && (wr_cnt_q == LAST_IDX);

  // Sample storage carries no reset; contents are irrelevant until rewritten
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_re_q[wr_bank_q][wr_cnt_q] <= din_re;
      mem_im_q[wr_bank_q][wr_cnt_q] <= din_im;
    end
  end

  always_comb begin
    drain_c = 1'b0;
    grp_c   = '0;
    state_d = state_q;
    unique case (state_q)
      ST_DRAIN0: begin drain_c = 1'b1; grp_c = 2'd0; state_d = ST_DRAIN1; end
      ST_DRAIN1: begin drain_c = 1'b1; grp_c = 2'd1; state_d = ST_DRAIN2; end
      ST_DRAIN2: begin drain_c = 1'b1; grp_c = 2'd2; state_d = ST_DRAIN3; end
      ST_DRAIN3: begin drain_c = 1'b1; grp_c = 2'd3; state_d = ST_IDLE;   end
      default:   state_d = ST_IDLE;
    endcase
    if (last_c) state_d = ST_DRAIN0;
  end

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    flag_d       = wr_en_c && (wr_cnt_q == FLAG_IDX);
    dout_valid_d = drain_c;
    dout_grp_d   = dout_grp_q;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;

    if (frame_clr) begin
      wr_cnt_d = '0;
    end else if (din_valid) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    if (last_c) begin
      wr_bank_d = ~wr_bank_q;
      rd_bank_d = wr_bank_q;
    end

    // Lane l of group g carries x[g + 4*l] (radix-4 DIF first-stage order)
    if (drain_c) begin
      dout_grp_d = grp_c;
      for (int l = 0; l < LANES; l++) begin
        dout_re_d[l*DATA_W +: DATA_W] = mem_re_q[rd_bank_q][{GRP_W'(l), grp_c}];
        dout_im_d[l*DATA_W +: DATA_W] = mem_im_q[rd_bank_q][{GRP_W'(l), grp_c}];
      end
    end
  end

`ifdef FFT_S_P_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (last_c) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      flag_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_grp_q   <= '0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      flag_q       <= flag_d;
      dout_valid_q <= dout_valid_d;
      dout_grp_q   <= dout_grp_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
    end
  end

  assign s_p_flag_out = flag_q;
  assign dout_valid   = dout_valid_q;
  assign dout_grp     = dout_grp_q;
  assign dout_re      = dout_re_q;
  assign dout_im      = dout_im_q;

endmodule

// File: tb/tb_fft_s_p.sv
// Self-checking bench for fft_s_p against a frame-level queue model.
// Build with +define+FFT_S_P_FRAME_CNT_EN to also exercise frame_cnt.
module tb_fft_s_p;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            din_valid = 1'b0;
  logic            frame_clr = 1'b0;
  logic [DW-1:0]   din_re = '0;
  logic [DW-1:0]   din_im = '0;
  logic            s_p_flag_out;
  logic            dout_valid;
  logic [1:0]      dout_grp;
  logic [4*DW-1:0] dout_re;
  logic [4*DW-1:0] dout_im;
`ifdef FFT_S_P_FRAME_CNT_EN
  logic [7:0]      frame_cnt;
`endif

  fft_s_p #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din_valid    (din_valid),
    .din_re       (din_re),
    .din_im       (din_im),
    .frame_clr    (frame_clr),
    .s_p_flag_out (s_p_flag_out),
    .dout_valid   (dout_valid),
    .dout_grp     (dout_grp),
    .dout_re      (dout_re),
    .dout_im      (dout_im)
`ifdef FFT_S_P_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;

  // Reference model: samples of the frame being collected, plus a timeline
  // of group presentations scheduled when a frame completes.
  logic [DW-1:0]   fq_re[$];
  logic [DW-1:0]   fq_im[$];
  logic            ev[N];
  logic [1:0]      eg[N];
  logic [4*DW-1:0] ere[N];
  logic [4*DW-1:0] eim[N];
  logic            m_flag, m_valid;
  logic [1:0]      m_grp;
  logic [4*DW-1:0] m_re, m_im;
  int              m_frames;
  logic [131:0]    obs, expv;

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) ev[i] = 1'b0;
    fq_re.delete();
    fq_im.delete();
    m_flag = 1'b0; m_valid = 1'b0; m_grp = '0; m_re = '0; m_im = '0;
    m_frames = 0;
  endtask

  // Drive one cycle, advance the model across the edge, sample 1 ns later
  task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input logic clr);
    int idx;
    din_valid = v; din_re = re; din_im = im; frame_clr = clr;
    @(posedge clk);
    cyc++;
    m_flag = 1'b0;
    if (clr) begin
      fq_re.delete();
      fq_im.delete();
    end else if (v) begin
      fq_re.push_back(re);
      fq_im.push_back(im);
      if (fq_re.size() == 13) m_flag = 1'b1;
      if (fq_re.size() == 16) begin
        for (int g = 0; g < 4; g++) begin
          idx = (cyc + 1 + g) % int'(N);
          ev[idx]  = 1'b1;
          eg[idx]  = 2'(g);
          ere[idx] = {fq_re[g+12], fq_re[g+8], fq_re[g+4], fq_re[g]};
          eim[idx] = {fq_im[g+12], fq_im[g+8], fq_im[g+4], fq_im[g]};
        end
        fq_re.delete();
        fq_im.delete();
        m_frames++;
      end
    end
    idx = cyc % int'(N);
    m_valid = ev[idx];
    if (ev[idx]) begin
      m_grp = eg[idx]; m_re = ere[idx]; m_im = eim[idx];
      ev[idx] = 1'b0;
    end
    #1;
    obs  = {s_p_flag_out, dout_valid, dout_grp, dout_re, dout_im};
    expv = {m_flag, m_valid, m_grp, m_re, m_im};
    din_valid = 1'b0; frame_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    obs = {s_p_flag_out, dout_valid, dout_grp, dout_re, dout_im};
    tests_run++;
    if (obs !== 132'd0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", obs);
    end
`ifdef FFT_S_P_FRAME_CNT_EN
    tests_run++;
    if (frame_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int nflag = 0;
    logic [4*DW-1:0] g1 = '0;
    for (int k = 0; k < 22; k++) begin
      if (k < 16) step(1'b1, DW'(k), DW'(-k), 1'b0);
      else        step(1'b0, '0, '0, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL basic cyc%0d got %h want %h", cyc, obs, expv);
      end
      nflag += int'(s_p_flag_out);
      if (dout_valid && dout_grp == 2'd1) g1 = dout_re;
    end
    tests_run++;
    if (nflag != 1) begin fails++; $display("FAIL basic_flag_count got %0d want 1", nflag); end
    tests_run++;
    if (g1 !== {16'd13, 16'd9, 16'd5, 16'd1}) begin
      fails++; $display("FAIL basic_group1 got %h want 000d000900050001", g1);
    end
  endtask

  task automatic test_gap();
    int nvalid = 0;
    int k = 0;
    for (int c = 0; c < 25; c++) begin
      if (k < 16 && !(c >= 6 && c < 9)) begin
        step(1'b1, DW'(k), DW'(-k), 1'b0);
        k++;
      end else begin
        step(1'b0, '0, '0, 1'b0);
      end
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL gap cyc%0d got %h want %h", cyc, obs, expv);
      end
      nvalid += int'(dout_valid);
    end
    tests_run++;
    if (nvalid != 4) begin fails++; $display("FAIL gap_valid_len got %0d want 4", nvalid); end
  endtask

  task automatic test_back_to_back();
    int flag_cyc[$];
    int ndrain = 0;
    logic [4*DW-1:0] g0 = '0;
    for (int k = 0; k < 54; k++) begin
      if (k < 48) step(1'b1, DW'(k), DW'(-k), 1'b0);
      else        step(1'b0, '0, '0, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL b2b cyc%0d got %h want %h", cyc, obs, expv);
      end
      if (s_p_flag_out) flag_cyc.push_back(cyc);
      if (dout_valid && dout_grp == 2'd0) begin
        ndrain++;
        if (ndrain == 3) g0 = dout_re;
      end
    end
    tests_run++;
    if (flag_cyc.size() != 3 || flag_cyc[1] - flag_cyc[0] != 16 || flag_cyc[2] - flag_cyc[1] != 16) begin
      fails++; $display("FAIL b2b_flag_spacing got %0d pulses want 3 at 16-cycle spacing", flag_cyc.size());
    end
    tests_run++;
    if (g0 !== {16'd44, 16'd40, 16'd36, 16'd32}) begin
      fails++; $display("FAIL b2b_third_group0 got %h want 002c002800240020", g0);
    end
  endtask

  task automatic test_frame_clr();
    int nflag = 0;
    logic saw99 = 1'b0;
    logic [4*DW-1:0] g0 = '0;
    for (int k = 0; k < 33; k++) begin
      if (k < 10)       step(1'b1, DW'(200 + k), DW'(k), 1'b0);
      else if (k == 10) step(1'b1, DW'(99), DW'(99), 1'b1);
      else if (k < 27)  step(1'b1, DW'(89 + k), DW'(k), 1'b0);
      else              step(1'b0, '0, '0, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL clr cyc%0d got %h want %h", cyc, obs, expv);
      end
      nflag += int'(s_p_flag_out);
      if (dout_valid && dout_grp == 2'd0) g0 = dout_re;
      for (int l = 0; l < 4; l++) if (dout_re[l*DW +: DW] == DW'(99)) saw99 = 1'b1;
    end
    tests_run++;
    if (nflag != 1) begin fails++; $display("FAIL clr_flag_count got %0d want 1", nflag); end
    tests_run++;
    if (g0 !== {16'd112, 16'd108, 16'd104, 16'd100} || saw99) begin
      fails++; $display("FAIL clr_group0 got %h saw99=%0d want 0070006c00680064 saw99=0", g0, saw99);
    end
  endtask

  task automatic test_reset_mid_drain();
    int budget = 0;
    for (int k = 0; k < 16; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);
    while (!(dout_valid && dout_grp == 2'd1) && budget < 10) begin
      step(1'b0, '0, '0, 1'b0);
      budget++;
    end
    tests_run++;
    if (budget >= 10) begin fails++; $display("FAIL rst_mid_wait got timeout want grp1"); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    obs = {s_p_flag_out, dout_valid, dout_grp, dout_re, dout_im};
    tests_run++;
    if (obs !== 132'd0) begin fails++; $display("FAIL rst_mid_outputs got %h want 0", obs); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k < 16) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);
      else        step(1'b0, '0, '0, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL rst_fresh cyc%0d got %h want %h", cyc, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c < 394)
        step($urandom_range(3, 0) != 0, DW'($urandom), DW'($urandom), $urandom_range(40, 0) == 0);
      else
        step(1'b0, '0, '0, 1'b0);
      tests_run++;
      if (obs !== expv) begin
        fails++; $display("FAIL random cyc%0d got %h want %h", cyc, obs, expv);
      end
    end
  endtask

`ifdef FFT_S_P_FRAME_CNT_EN
  task automatic test_frame_cnt();
    test_reset();
    for (int f = 0; f < 257; f++) begin
      for (int k = 0; k < 16; k++) begin
        step(1'b1, DW'($urandom), DW'($urandom), 1'b0);
        tests_run++;
        if (obs !== expv) begin
          fails++; $display("FAIL fcnt_data cyc%0d got %h want %h", cyc, obs, expv);
        end
      end
      tests_run++;
      if (frame_cnt !== 8'(m_frames)) begin
        fails++; $display("FAIL fcnt_track got %0d want %0d", frame_cnt, 8'(m_frames));
      end
    end
    step(1'b0, '0, '0, 1'b1);
    tests_run++;
    if (frame_cnt !== 8'd1) begin fails++; $display("FAIL fcnt_wrap got %0d want 1", frame_cnt); end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_gap();
    test_back_to_back();
    test_frame_clr();
    test_reset_mid_drain();
    test_random();
`ifdef FFT_S_P_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
